// File: rtl/oam_dma_controller.sv
// Sprite DMA: a write to DMA_REG_ADDR stalls the core and copies 256 bytes of a CPU page to OAMDATA.
// Define OAM_DMA_ALIGN_EN to insert an ALIGN cycle so every READ lands on an even bus cycle.
module oam_dma_controller #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ph2_rising,
  input  logic        ph2_falling,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rnw,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_rdy,
  output logic [15:0] mem_addr,
  output logic        mem_rnw,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active
);

  typedef enum logic [2:0] {S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE} state_t;

  state_t      state;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  byte_reg;
  logic [15:0] dma_addr;
  logic        dma_rnw;
  logic        trigger;
  logic        go_align;

  assign trigger = ph2_falling && !cpu_rnw && (cpu_addr == DMA_REG_ADDR);

`ifdef OAM_DMA_ALIGN_EN
  logic cyc_par;
  // HALT on an even cycle leaves the next one odd, so burn one more cycle.
  assign go_align = !cyc_par;

  always_ff @(posedge clk) begin
    if (rst)              cyc_par <= 1'b0;
    else if (ph2_falling) cyc_par <= ~cyc_par;
  end
`else
  assign go_align = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      page       <= 8'h00;
      idx        <= 8'h00;
      byte_reg   <= 8'h00;
      dma_addr   <= 16'h0000;
      dma_rnw    <= 1'b1;
      dma_active <= 1'b0;
      cpu_rdy    <= 1'b1;
    end else if (ph2_falling) begin
      case (state)
        S_IDLE: if (trigger) begin
          page       <= cpu_wdata;
          idx        <= 8'h00;
          dma_addr   <= {cpu_wdata, 8'h00};
          dma_rnw    <= 1'b1;
          dma_active <= 1'b1;
          cpu_rdy    <= 1'b0;
          state      <= S_HALT;
        end
        S_HALT: begin
          dma_addr <= {page, 8'h00};
          dma_rnw  <= 1'b1;
          state    <= go_align ? S_ALIGN : S_READ;
        end
        S_ALIGN: begin
          dma_addr <= {page, idx};
          dma_rnw  <= 1'b1;
          state    <= S_READ;
        end
        S_READ: begin
          byte_reg <= mem_rdata;
          dma_addr <= OAM_DATA_ADDR;
          dma_rnw  <= 1'b0;
          state    <= S_WRITE;
        end
        S_WRITE: begin
          if (idx == 8'hFF) begin
            dma_rnw    <= 1'b1;
            dma_active <= 1'b0;
            cpu_rdy    <= 1'b1;
            state      <= S_IDLE;
          end else begin
            idx      <= idx + 8'd1;
            dma_addr <= {page, idx + 8'd1};
            dma_rnw  <= 1'b1;
            state    <= S_READ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The DMA drive is registered; only the idle passthrough is combinational.
  assign mem_addr  = dma_active ? dma_addr : cpu_addr;
  assign mem_rnw   = dma_active ? dma_rnw  : cpu_rnw;
  assign mem_wdata = dma_active ? byte_reg : cpu_wdata;

  // Phase strobes must never coincide, or the address setup window collapses.
  a_ph2_disjoint: assert property (@(posedge clk) disable iff (rst) !(ph2_rising && ph2_falling));

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: passthrough vectors, full DMAs at both parities, reset mid-transfer.
module tb_oam_dma_controller;

`ifdef OAM_DMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ph2_rising, ph2_falling;
  logic [15:0] cpu_addr;
  logic        cpu_rnw;
  logic [7:0]  cpu_wdata;
  logic        cpu_rdy;
  logic [15:0] mem_addr;
  logic        mem_rnw;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        dma_active;

  oam_dma_controller dut (
    .clk(clk), .rst(rst), .ph2_rising(ph2_rising), .ph2_falling(ph2_falling),
    .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw), .cpu_wdata(cpu_wdata), .cpu_rdy(cpu_rdy),
    .mem_addr(mem_addr), .mem_rnw(mem_rnw), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         wr_cnt = 0;
  int         stall_cnt = 0;
  logic       tb_par = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] wram[0:2047];

  assign mem_rdata = wram[mem_addr[10:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus cycle of 6 clks: ph2_falling at phase 0, ph2_rising at phase 3.
  initial begin
    ph2_falling = 1'b0;
    ph2_rising  = 1'b0;
    forever begin
      for (int ph = 0; ph < 6; ph++) begin
        @(posedge clk);
        #1;
        ph2_falling = (ph == 0);
        ph2_rising  = (ph == 3);
      end
    end
  end

  // Monitor: samples each bus-cycle boundary on the preceding negedge.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) tb_par = 1'b0;
      else if (ph2_falling) begin
        if (!cpu_rdy) stall_cnt++;
        if (dma_active && !mem_rnw && mem_addr == 16'h2004) begin
          wr_cnt++;
          if (exp_q.size() == 0) chk("unexpected_oam_write", 32'(wr_cnt), 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("oam_data", 32'(mem_wdata), 32'(e));
          end
        end
        tb_par = ~tb_par;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [15:0] a, input logic rnw, input logic [7:0] d);
    cpu_addr  = a;
    cpu_rnw   = rnw;
    cpu_wdata = d;
  endtask

  // Finish the current bus cycle and return at the first negedge of the next one.
  task automatic finish_cyc();
    @(negedge clk);
    while (!ph2_falling) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic cyc(input logic [15:0] a, input logic rnw, input logic [7:0] d);
    drive(a, rnw, d);
    finish_cyc();
  endtask

  task automatic run_dma(input logic trig_par, input int exp_stall, input string tag);
    int n;
    while (tb_par != trig_par) cyc(16'h0000, 1'b1, 8'h00);
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i) ^ 8'hA5);
    stall_cnt = 0;
    wr_cnt    = 0;
    cyc(16'h4014, 1'b0, 8'h02);
    chk({tag, "_started"}, 32'(dma_active), 32'd1);
    chk({tag, "_rdy_low"}, 32'(cpu_rdy), 32'd0);
    chk({tag, "_halt_addr"}, 32'(mem_addr), 32'h0200);
    n = 0;
    while (!cpu_rdy && n < 700) begin
      cyc(16'h0000, 1'b1, 8'h00);
      n++;
    end
    chk({tag, "_done"}, 32'(cpu_rdy), 32'd1);
    chk({tag, "_stall"}, 32'(stall_cnt), 32'(exp_stall));
    chk({tag, "_writes"}, 32'(wr_cnt), 32'd256);
    chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_inactive"}, 32'(dma_active), 32'd0);
    exp_q.delete();
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        rnw;
    logic [7:0]  wdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    bit ok;
    vecs[0] = '{16'h0123, 1'b0, 8'h5A};
    vecs[1] = '{16'h4014, 1'b1, 8'h02};
    vecs[2] = '{16'h4015, 1'b0, 8'h02};
    vecs[3] = '{16'h4013, 1'b0, 8'h02};
    vecs[4] = '{16'h2002, 1'b1, 8'h00};
    vecs[5] = '{16'h07FF, 1'b0, 8'hC3};
    for (int i = 0; i < 2048; i++) wram[i] = 8'h00;
    for (int i = 0; i < 256; i++) wram[16'h0200 + i] = 8'(i) ^ 8'hA5;

    rst = 1'b1;
    drive(16'h1234, 1'b0, 8'h3C);
    repeat (20) @(negedge clk);
    chk("reset_rdy", 32'(cpu_rdy), 32'd1);
    chk("reset_active", 32'(dma_active), 32'd0);
    chk("reset_pass_addr", 32'(mem_addr), 32'h1234);
    chk("reset_pass_wdata", 32'(mem_wdata), 32'h3C);
    rst = 1'b0;
    @(negedge clk);
    while (!ph2_falling) @(negedge clk);
    @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].addr, vecs[i].rnw, vecs[i].wdata);
      #1;
      chk("pass_addr", 32'(mem_addr), 32'(vecs[i].addr));
      chk("pass_rnw", 32'(mem_rnw), 32'(vecs[i].rnw));
      chk("pass_wdata", 32'(mem_wdata), 32'(vecs[i].wdata));
      chk("pass_rdy", 32'(cpu_rdy), 32'd1);
      finish_cyc();
      chk("no_trigger_active", 32'(dma_active), 32'd0);
      chk("no_trigger_rdy", 32'(cpu_rdy), 32'd1);
    end

    // Trigger on parity 0 puts HALT on parity 1: READs are already even.
    run_dma(1'b0, 513, "dma_even");
    run_dma(1'b1, ALIGN_EN ? 514 : 513, "dma_odd");

    // Reset while WRITE idx=100 is on the bus: only 100 writes completed.
    while (tb_par != 1'b0) cyc(16'h0000, 1'b1, 8'h00);
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i) ^ 8'hA5);
    wr_cnt = 0;
    cyc(16'h4014, 1'b0, 8'h02);
    drive(16'h0000, 1'b1, 8'h00);
    n = 0;
    while (mem_addr != 16'h0264 && n < 5000) begin @(negedge clk); n++; end
    while (mem_addr != 16'h2004 && n < 5000) begin @(negedge clk); n++; end
    ok = (n < 5000);
    chk("rst_mid_reached_write100", 32'(ok), 32'd1);
    chk("rst_mid_writes_before", 32'(wr_cnt), 32'd100);
    rst = 1'b1;
    drive(16'h0321, 1'b0, 8'h77);
    @(negedge clk);
    chk("rst_mid_rdy", 32'(cpu_rdy), 32'd1);
    chk("rst_mid_active", 32'(dma_active), 32'd0);
    chk("rst_mid_pass_addr", 32'(mem_addr), 32'h0321);
    chk("rst_mid_pass_rnw", 32'(mem_rnw), 32'd0);
    chk("rst_mid_pass_wdata", 32'(mem_wdata), 32'h77);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) cyc(16'h0000, 1'b1, 8'h00);
    chk("rst_mid_writes_after", 32'(wr_cnt), 32'd100);
    chk("rst_mid_stays_idle", 32'(dma_active), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
